pwm_capture: RTL

Measures an incoming PWM waveform, the receive-side counterpart of the team's PWM generator. It reports the period and high time in clk cycles, measured rising edge to rising edge. It sits on the peripheral clock and feeds the same register bank that holds period/compare values, so firmware can read back measured duty. It is also used as a loopback checker on pwm_out.

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_sync_edge.sv | 52 +++++
 rtl/pwm_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM input-capture blocks.
//   state_t      : capture FSM states (IDLE, ARM, HIGH, LOW)
//   PWM_CNT_W    : default width of the cycle counter and measurement outputs
//   PWM_CNT_MAX  : saturation value of a counter of the default width
//   cnt_max()    : saturation value for an arbitrary counter width
// -----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam int PWM_CNT_W = 16;
    localparam logic [PWM_CNT_W-1:0] PWM_CNT_MAX = {PWM_CNT_W{1'b1}};

    // All-ones value for a counter of the given width (width <= 32).
    function automatic logic [31:0] cnt_max(input int width);
        logic [31:0] val;
        val = '0;
        for (int i = 0; i < width && i < 32; i++) begin
            val[i] = 1'b1;
        end
        return val;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_sync_edge
// Brings an asynchronous level into the clk domain and reports its edges.
// pwm_in passes through SYNC_STAGES flops; the synchronized level is then
// optionally inverted and compared with its previous sample. rise/fall are
// combinational from registers and appear SYNC_STAGES cycles after pwm_in
// changes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   invert     : 1 = input is active-low (applied after synchronization)
//   pwm_in     : asynchronous input
//   rise, fall : single-cycle edge strobes of the (possibly inverted) level
// -----------------------------------------------------------------------------
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic invert,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
        end
    end

    // Inversion sits after the synchronizer so the metastability chain only
    // ever sees the raw pin.
    assign level = sync_reg[SYNC_STAGES-1] ^ invert;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;
    assign fall = ~level & prev_reg;

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures period and high time of a PWM input in clk cycles, rising edge to
// rising edge. A result is only published after a complete rise-fall-rise
// sequence; a counter that saturates without a closing edge sets a sticky
// overflow flag and re-arms.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   cap_en      : capture enable (0 returns to IDLE, results hold)
//   invert      : treat pwm_in as active-low; change only while cap_en = 0
//   ovf_clr     : clears ovf (a simultaneous new overflow wins)
//   pwm_in      : asynchronous PWM input
//   period_out  : last complete period in cycles
//   high_out    : high time belonging to period_out
//   meas_valid  : one-cycle pulse when period_out/high_out update
//   busy        : 1 while measuring (HIGH or LOW)
//   ovf         : sticky counter-saturation flag
// -----------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic             invert,
    input  logic             ovf_clr,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             busy,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] high_lat_reg, high_lat_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [CNT_W-1:0] high_reg, high_next;
    logic             valid_reg, valid_next;
    logic             ovf_reg, ovf_next;
    logic             saturate;
    logic             rise, fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .invert (invert),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            high_lat_reg <= '0;
            period_reg   <= '0;
            high_reg     <= '0;
            valid_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            high_lat_reg <= high_lat_next;
            period_reg   <= period_next;
            high_reg     <= high_next;
            valid_reg    <= valid_next;
            ovf_reg      <= ovf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        high_lat_next = high_lat_reg;
        period_next   = period_reg;
        high_next     = high_reg;
        valid_next    = 1'b0;
        ovf_next      = ovf_clr ? 1'b0 : ovf_reg;
        saturate      = 1'b0;

        if (!cap_en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next   = '0;
                    state_next = ARM;
                end
                ARM: begin
                    // A level already high at enable is ignored: only a
                    // genuine rise opens a measurement.
                    cnt_next = '0;
                    if (rise) begin
                        cnt_next   = CNT_ONE;
                        state_next = HIGH;
                    end
                end
                HIGH: begin
                    cnt_next = cnt_reg + CNT_ONE;
                    if (rise) begin
                        // Cannot happen with a single-sample edge detector;
                        // closed as a period with the whole interval high.
                        period_next = cnt_reg;
                        high_next   = cnt_reg;
                        valid_next  = 1'b1;
                        cnt_next    = CNT_ONE;
                    end else if (fall) begin
                        high_lat_next = cnt_reg;
                        state_next    = LOW;
                    end else if (cnt_reg == CNT_MAX) begin
                        saturate = 1'b1;
                    end
                end
                LOW: begin
                    cnt_next = cnt_reg + CNT_ONE;
                    if (rise) begin
                        // Closing rise is also the opening rise of the next
                        // period, so measurement continues without re-arming.
                        period_next = cnt_reg;
                        high_next   = high_lat_reg;
                        valid_next  = 1'b1;
                        cnt_next    = CNT_ONE;
                        state_next  = HIGH;
                    end else if (cnt_reg == CNT_MAX) begin
                        saturate = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase

            if (saturate) begin
                ovf_next   = 1'b1;
                cnt_next   = '0;
                state_next = ARM;
            end
        end
    end

    assign period_out = period_reg;
    assign high_out   = high_reg;
    assign meas_valid = valid_reg;
    assign ovf        = ovf_reg;
    assign busy       = (state_reg == HIGH) || (state_reg == LOW);

endmodule
